datapath_ctrl: RTL and testbench
================================

Name: datapath_ctrl

Overview:
Multi-cycle control unit that sequences the Datapath block (register file, ALU, data RAM). It fetches 16-bit instructions over a request/acknowledge instruction-memory port and decodes them. For each instruction it drives the datapath's register addresses, ALU selects, memory strobes and write enable in a fixed state sequence. It sits between the top-level start/status interface and the Datapath instance.

Parameters:
PC_W, 8, program counter / instruction address width
CNT_W, 16, retired-instruction counter width

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins execution from pc=0 when in IDLE
imem_req  output  1  instruction fetch request
imem_addr  output  PC_W  fetch address (= pc)
imem_ack  input  1  fetch data valid this cycle
imem_data  input  16  instruction word
address  output  8  data-memory address to Datapath
read_reg1  output  4  register file read port 1 address
read_reg2  output  4  register file read port 2 address
write_reg  output  4  register file write address
alu_imm_val  output  4  ALU immediate
alu_imm  output  1  ALU uses immediate instead of src2
alu_slc  output  1  ALU operation select
we  output  1  register write strobe
mem_store  output  1  data RAM store strobe
mem_load  output  1  data RAM load strobe
busy  output  1  high in any state except IDLE/HALT
halted  output  1  high in HALT
illegal  output  1  sticky; set on undefined opcode
retired  output  CNT_W  instructions completed, saturating

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (clr).
- Reset: state=IDLE, pc=0, IR=0. All outputs are 0, including retired and illegal.
- Instruction format: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2/imm. For LOAD/STORE, [7:0] is the data address.
- Opcodes:
  - 0 NOP
  - 1 ALU reg, slc=0
  - 2 ALU reg, slc=1
  - 3 ALU imm, slc=0
  - 4 ALU imm, slc=1
  - 5 LOAD rd <- mem[addr]
  - 6 STORE mem[addr] <- rd
  - 7 HALT
  - 8-15 illegal
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: start=1 -> FETCH with pc=0, illegal cleared, retired cleared.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Stay until imem_ack=1; there is no timeout.
  - On ack, latch IR=imem_data, pc<=pc+1 (wraps 255->0), go to DECODE.
  - imem_req drops the cycle after ack.
- DECODE (1 cycle): register all datapath controls from IR; these hold constant through EXEC/MEM/WB.
  - read_reg1=rs1, read_reg2=rs2, write_reg=rd, alu_imm_val=imm.
  - alu_imm=1 for op 3/4; alu_slc=1 for op 2/4.
  - address=IR[7:0] for op 5/6, else 0.
  - For STORE, read_reg1=rd.
- DECODE transitions:
  - NOP -> FETCH, retired+1.
  - HALT -> HALT, retired+1.
  - Illegal -> HALT, illegal=1, retired unchanged.
  - Otherwise -> EXEC.
- EXEC:
  - ALU ops: we=1 for exactly this cycle, then FETCH, retired+1.
  - LOAD/STORE -> MEM.
- MEM:
  - LOAD: mem_load=1 for one cycle, then WB.
  - STORE: mem_store=1 for one cycle, then FETCH, retired+1.
- WB (LOAD only): we=1 for one cycle, write_reg=rd, then FETCH, retired+1.
- Strobe rules: we, mem_load and mem_store are single-cycle pulses and never more than one is high in the same cycle.
- Cycles per instruction, excluding fetch wait:
  - NOP: 2 (FETCH-ack + DECODE).
  - ALU: 3.
  - STORE: 4.
  - LOAD: 5.
- HALT: all strobes 0, halted=1. start=1 restarts as from IDLE (pc=0, counters cleared).
- start outside IDLE/HALT is ignored.
- retired saturates at 2^CNT_W-1.
- Reset asserted mid-instruction: immediate return to reset values, with any strobe dropped asynchronously. No partial write completes after reset releases.

Test Plan:
- Reset then start; program [0x3123 ALU-imm rd=1 rs1=2 imm=3, 0x7000] with ack after 1 cycle -> we pulses once with write_reg=1, alu_imm=1, alu_imm_val=3, alu_slc=0; halted=1; retired=2; pc=2.
- Program [0x5A40 LOAD rd=A addr=0x40, 0x6B41 STORE rd=B addr=0x41, 0x7000] -> LOAD: mem_load pulse at address=0x40, next cycle we with write_reg=A. STORE: mem_store pulse, read_reg1=B, address=0x41, we never high. retired=3.
- imem_ack delayed 5 cycles on each fetch -> imem_req held high with stable imem_addr for all waiting cycles; no strobes during the wait.
- Opcode 0x9xxx at pc=0 -> illegal=1, halted=1, retired=0, no we/mem strobes; start then clears illegal and refetches pc=0.
- clr asserted in the cycle EXEC drives we=1 -> we falls immediately; state=IDLE, pc=0; after release no write occurs until a new start.
- 256 NOPs with no HALT -> pc wraps from 255 to 0; imem_addr=0 on the 257th fetch; retired=256.

Source files
------------

// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer: fetches 16-bit instructions and drives the datapath's register, ALU and RAM controls.
// Latency: NOP 2, ALU 3, STORE 4, LOAD 5 cycles per instruction, plus however long the fetch waits for imem_ack.
// Backpressure: FETCH holds imem_req high with a stable imem_addr until imem_ack; start is ignored while busy.
module datapath_ctrl #(
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic             imem_ack,
   input  logic [15:0]      imem_data,
   output logic [7:0]       address,
   output logic [3:0]       read_reg1,
   output logic [3:0]       read_reg2,
   output logic [3:0]       write_reg,
   output logic [3:0]       alu_imm_val,
   output logic             alu_imm,
   output logic             alu_slc,
   output logic             we,
   output logic             mem_store,
   output logic             mem_load,
   output logic             busy,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_LOAD  = 4'd5;
   localparam logic [3:0] OP_STORE = 4'd6;
   localparam logic [3:0] OP_HALT  = 4'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PC_W-1:0] pc;
   logic [15:0]     ir;
   logic [3:0]      op;
   logic            is_alu;
   logic            is_mem;
   logic            retire_evt;
   logic            illegal_set;
   logic            restart;

   assign op     = ir[15:12];
   assign is_alu = (op >= 4'd1) && (op <= 4'd4);
   assign is_mem = (op == OP_LOAD) || (op == OP_STORE);

   // Strobes are decoded combinationally from the state so that an asynchronous
   // reset removes them in the same instant the state register clears.
   assign imem_addr = pc;
   assign busy      = (state != S_IDLE) && (state != S_HALT);
   assign halted    = (state == S_HALT);

   // State register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic, strobes and bookkeeping events
   always_comb begin
      state_nxt   = state;
      imem_req    = 1'b0;
      we          = 1'b0;
      mem_load    = 1'b0;
      mem_store   = 1'b0;
      retire_evt  = 1'b0;
      illegal_set = 1'b0;
      restart     = 1'b0;
      case (state)
         S_IDLE, S_HALT: begin
            if (start) begin
               restart   = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            if (op == OP_NOP) begin
               retire_evt = 1'b1;
               state_nxt  = S_FETCH;
            end else if (op == OP_HALT) begin
               retire_evt = 1'b1;
               state_nxt  = S_HALT;
            end else if (is_alu || is_mem) begin
               state_nxt  = S_EXEC;
            end else begin
               // Undefined opcode: stop without counting it as retired.
               illegal_set = 1'b1;
               state_nxt   = S_HALT;
            end
         end
         S_EXEC: begin
            if (is_alu) begin
               we         = 1'b1;
               retire_evt = 1'b1;
               state_nxt  = S_FETCH;
            end else begin
               state_nxt  = S_MEM;
            end
         end
         S_MEM: begin
            if (op == OP_LOAD) begin
               mem_load  = 1'b1;
               state_nxt = S_WB;
            end else begin
               mem_store  = 1'b1;
               retire_evt = 1'b1;
               state_nxt  = S_FETCH;
            end
         end
         S_WB: begin
            we         = 1'b1;
            retire_evt = 1'b1;
            state_nxt  = S_FETCH;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Program counter and instruction register; pc wraps naturally at 2^PC_W
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pc <= '0;
         ir <= '0;
      end else if (restart) begin
         pc <= '0;
      end else if ((state == S_FETCH) && imem_ack) begin
         ir <= imem_data;
         pc <= pc + PC_W'(1);
      end
   end

   // Datapath controls captured at the end of DECODE and held through EXEC/MEM/WB
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         address     <= '0;
         read_reg1   <= '0;
         read_reg2   <= '0;
         write_reg   <= '0;
         alu_imm_val <= '0;
         alu_imm     <= 1'b0;
         alu_slc     <= 1'b0;
      end else if (state == S_DECODE) begin
         address     <= is_mem ? ir[7:0] : 8'h00;
         // STORE reads the register named in the rd field as its data source.
         read_reg1   <= (op == OP_STORE) ? ir[11:8] : ir[7:4];
         read_reg2   <= ir[3:0];
         write_reg   <= ir[11:8];
         alu_imm_val <= ir[3:0];
         alu_imm     <= (op == 4'd3) || (op == 4'd4);
         alu_slc     <= (op == 4'd2) || (op == 4'd4);
      end
   end

   // Sticky illegal flag and saturating retired-instruction counter, both cleared by a (re)start
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         illegal <= 1'b0;
         retired <= '0;
      end else if (restart) begin
         illegal <= 1'b0;
         retired <= '0;
      end else begin
         if (illegal_set) begin
            illegal <= 1'b1;
         end
         if (retire_evt && (retired != {CNT_W{1'b1}})) begin
            retired <= retired + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: instruction-memory responder with programmable ack delay plus a strobe scoreboard.
// Latency: expected strobe events are queued when an instruction is acked and retired when the DUT pulses a strobe.
// Backpressure: the responder withholds imem_ack for ack_delay cycles to exercise fetch stalls.
module tb_datapath_ctrl;

   logic        clk;
   logic        clr;
   logic        start;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic [7:0]  address;
   logic [3:0]  read_reg1;
   logic [3:0]  read_reg2;
   logic [3:0]  write_reg;
   logic [3:0]  alu_imm_val;
   logic        alu_imm;
   logic        alu_slc;
   logic        we;
   logic        mem_store;
   logic        mem_load;
   logic        busy;
   logic        halted;
   logic        illegal;
   logic [15:0] retired;

   datapath_ctrl #(.PC_W(8), .CNT_W(16)) dut (
      .clk(clk), .clr(clr), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .address(address), .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
      .alu_imm_val(alu_imm_val), .alu_imm(alu_imm), .alu_slc(alu_slc),
      .we(we), .mem_store(mem_store), .mem_load(mem_load),
      .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
   );

   int unsigned n_checks = 0;
   int unsigned n_errs   = 0;
   logic [15:0] prog [256];
   logic [31:0] sb_q [$];
   logic [7:0]  exp_pc = 8'h00;
   int          ack_delay = 1;
   int          fetch_cnt = 0;
   int          we_cnt = 0;
   logic [2:0]  strb;

   assign strb = {we, mem_load, mem_store};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // kind: 0 = we, 1 = mem_load, 2 = mem_store
   function automatic logic [31:0] pack_ev(input logic [1:0] kind, input logic [7:0] addr,
                                           input logic [3:0] rr1, input logic [3:0] rr2,
                                           input logic [3:0] wr, input logic [3:0] imm,
                                           input logic ai, input logic as);
      return {2'b00, kind, addr, rr1, rr2, wr, imm, ai, as, 2'b00};
   endfunction

   // Reference decode: queue every strobe the instruction must produce, in order.
   task automatic push_events(input logic [15:0] w);
      logic [3:0] op;
      logic [7:0] addr;
      logic [3:0] rr1;
      logic       ai;
      logic       as;
      op   = w[15:12];
      addr = (op == 4'd5 || op == 4'd6) ? w[7:0] : 8'h00;
      rr1  = (op == 4'd6) ? w[11:8] : w[7:4];
      ai   = (op == 4'd3 || op == 4'd4);
      as   = (op == 4'd2 || op == 4'd4);
      if (op >= 4'd1 && op <= 4'd4) begin
         sb_q.push_back(pack_ev(2'd0, addr, rr1, w[3:0], w[11:8], w[3:0], ai, as));
      end else if (op == 4'd5) begin
         sb_q.push_back(pack_ev(2'd1, addr, rr1, w[3:0], w[11:8], w[3:0], ai, as));
         sb_q.push_back(pack_ev(2'd0, addr, rr1, w[3:0], w[11:8], w[3:0], ai, as));
      end else if (op == 4'd6) begin
         sb_q.push_back(pack_ev(2'd2, addr, rr1, w[3:0], w[11:8], w[3:0], ai, as));
      end
   endtask

   // Instruction memory responder
   initial begin : responder
      int   wait_cnt;
      bit   in_fetch;
      logic [7:0] first_addr;
      imem_ack   = 1'b0;
      imem_data  = 16'h0000;
      wait_cnt   = 0;
      in_fetch   = 1'b0;
      first_addr = 8'h00;
      forever begin
         @(negedge clk);
         if (!clr) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
            in_fetch = 1'b0;
         end else if (imem_ack) begin
            imem_ack = 1'b0;
            in_fetch = 1'b0;
            wait_cnt = 0;
            check_val("req_drop", 32'(imem_req), 32'd0);
         end else if (imem_req) begin
            if (!in_fetch) begin
               in_fetch   = 1'b1;
               fetch_cnt++;
               first_addr = imem_addr;
               check_val("fetch_addr", 32'(imem_addr), 32'(exp_pc));
            end else begin
               check_val("wait_addr", 32'(imem_addr), 32'(first_addr));
            end
            check_val("wait_strobe", 32'(strb), 32'd0);
            if (wait_cnt >= ack_delay) begin
               imem_ack  = 1'b1;
               imem_data = prog[imem_addr];
               push_events(prog[imem_addr]);
               exp_pc    = exp_pc + 8'd1;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // Strobe monitor: every strobe must be one-hot and match the head of the scoreboard
   initial begin : monitor
      logic [31:0] ev;
      logic [1:0]  kind;
      forever begin
         @(negedge clk);
         if (clr && (strb != 3'b000)) begin
            if (we) we_cnt++;
            check_val("strobe_onehot", 32'($countones(strb)), 32'd1);
            kind = we ? 2'd0 : (mem_load ? 2'd1 : 2'd2);
            ev   = pack_ev(kind, address, read_reg1, read_reg2, write_reg, alu_imm_val, alu_imm, alu_slc);
            check_val("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               check_val("strobe_ev", ev, sb_q.pop_front());
            end
         end
      end
   end

   task automatic do_start();
      exp_pc = 8'h00;
      start  = 1'b1;
      @(negedge clk);
      #1;
      start  = 1'b0;
   endtask

   task automatic wait_halt(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         if (halted) break;
         @(negedge clk);
         #1;
      end
      check_val("halt_reached", 32'(halted), 32'd1);
   endtask

   task automatic check_halt_state(input string tag, input int exp_ret, input int exp_addr, input bit exp_ill);
      check_val({tag, "_retired"}, 32'(retired), 32'(exp_ret));
      check_val({tag, "_pc"}, 32'(imem_addr), 32'(exp_addr));
      check_val({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
      check_val({tag, "_busy"}, 32'(busy), 32'd0);
      check_val({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic apply_reset();
      clr = 1'b0;
      sb_q.delete();
      @(negedge clk);
      @(negedge clk);
      #1;
      clr = 1'b1;
   endtask

   initial begin : main
      start = 1'b0;
      clr   = 1'b0;
      for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
      #12;
      // Reset values
      check_val("rst_status", {busy, halted, illegal, imem_req, we, mem_load, mem_store}, 32'd0);
      check_val("rst_retired", 32'(retired), 32'd0);
      check_val("rst_pc", 32'(imem_addr), 32'd0);
      check_val("rst_ctrl", {address, read_reg1, read_reg2, write_reg, alu_imm_val, alu_imm, alu_slc}, 32'd0);
      @(negedge clk);
      #1;
      clr = 1'b1;

      // ALU-immediate then HALT, ack after one cycle
      ack_delay = 1;
      prog[0] = 16'h3123;
      prog[1] = 16'h7000;
      we_cnt  = 0;
      do_start();
      wait_halt(100);
      check_halt_state("alu_imm", 2, 2, 1'b0);
      check_val("alu_imm_we_cnt", 32'(we_cnt), 32'd1);

      // LOAD, STORE, HALT (restart straight from HALT)
      prog[0] = 16'h5A40;
      prog[1] = 16'h6B41;
      prog[2] = 16'h7000;
      we_cnt  = 0;
      do_start();
      wait_halt(100);
      check_halt_state("ldst", 3, 3, 1'b0);
      check_val("ldst_we_cnt", 32'(we_cnt), 32'd1);

      // Register ALU ops with five-cycle fetch stalls
      ack_delay = 5;
      prog[0] = 16'h2456;
      prog[1] = 16'h4789;
      prog[2] = 16'h1ABC;
      prog[3] = 16'h7000;
      do_start();
      wait_halt(200);
      check_halt_state("stall", 4, 4, 1'b0);

      // Illegal opcode at pc=0
      ack_delay = 0;
      prog[0] = 16'h9123;
      do_start();
      wait_halt(100);
      check_halt_state("illegal", 0, 1, 1'b1);
      prog[0] = 16'h7000;
      do_start();
      check_val("restart_illegal_clr", 32'(illegal), 32'd0);
      check_val("restart_pc", 32'(imem_addr), 32'd0);
      check_val("restart_req", 32'(imem_req), 32'd1);
      wait_halt(100);
      check_halt_state("refetch", 1, 1, 1'b0);

      // Reset during the EXEC write strobe
      prog[0] = 16'h1123;
      prog[1] = 16'h7000;
      do_start();
      for (int i = 0; i < 50; i++) begin
         if (we) break;
         @(negedge clk);
         #1;
      end
      check_val("exec_we_seen", 32'(we), 32'd1);
      clr = 1'b0;
      sb_q.delete();
      #1;
      check_val("arst_we", 32'(we), 32'd0);
      check_val("arst_busy", 32'(busy), 32'd0);
      check_val("arst_pc", 32'(imem_addr), 32'd0);
      check_val("arst_retired", 32'(retired), 32'd0);
      @(negedge clk);
      #1;
      clr    = 1'b1;
      we_cnt = 0;
      repeat (20) @(negedge clk);
      #1;
      check_val("post_arst_we_cnt", 32'(we_cnt), 32'd0);
      check_val("post_arst_idle", {busy, halted, imem_req}, 32'd0);

      // 256 NOPs: pc wraps and the 257th fetch is from address 0
      for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
      fetch_cnt = 0;
      do_start();
      for (int i = 0; i < 2000; i++) begin
         if (fetch_cnt >= 257) break;
         @(negedge clk);
         #1;
      end
      check_val("wrap_fetches", 32'(fetch_cnt), 32'd257);
      check_val("wrap_pc", 32'(imem_addr), 32'd0);
      check_val("wrap_retired", 32'(retired), 32'd256);
      apply_reset();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
